// File: rtl/rob_pkg.sv
// rob_pkg: types and constants shared by the sequence-number allocator and the ROB controller.
`default_nettype none
package rob_pkg;

  localparam int ROB_DEPTH = 32;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } rob_sn_state_e;

endpackage
`default_nettype wire

// File: rtl/rob_sn_ptr.sv
// rob_sn_ptr: wrapping pointer register; power-of-two range so wrap is the natural carry-out.
`default_nettype none
module rob_sn_ptr #(
  parameter int p_width = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [p_width-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + p_width'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_sn_alloc.sv
// rob_sn_alloc: in-order sequence-number allocator for the reorder buffer.
// Optional drain FSM enabled by macro ROB_SN_ALLOC_DRAIN_EN.
`ifndef ROB_SN_ALLOC_V
`define ROB_SN_ALLOC_V
`default_nettype none
module rob_sn_alloc
  import rob_pkg::*;
#(
  parameter int p_depth    = ROB_DEPTH,
  parameter int p_ptrwidth = $clog2(p_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  output logic                  alloc_cpl,
  output logic [p_ptrwidth-1:0] alloc_sn,
  input  logic                  ret_en,
  output logic [p_ptrwidth-1:0] ret_sn,
  output logic [p_ptrwidth:0]   count,
  output logic                  full,
  output logic                  empty,
  input  logic                  drain_req,
  output logic                  drain_done
);

  logic [p_ptrwidth:0]   count_q;
  logic [p_ptrwidth-1:0] alloc_ptr;
  logic [p_ptrwidth-1:0] ret_ptr;
  logic                  full_int;
  logic                  empty_int;
  logic                  grant;
  logic                  ret_ok;

  assign full_int  = (count_q == (p_ptrwidth+1)'(p_depth));
  assign empty_int = (count_q == '0);
  assign ret_ok    = ret_en && !empty_int && !rst;

`ifdef ROB_SN_ALLOC_DRAIN_EN
  rob_sn_state_e state_q;
  rob_sn_state_e state_d;
  logic          done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain exits on the first cycle the allocator is observed empty, even if entered empty.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      NORMAL: if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (empty_int) begin
          state_d = NORMAL;
          done    = 1'b1;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  assign grant      = alloc_en && !full_int && (state_q == NORMAL) && !drain_req && !rst;
  assign drain_done = done && !rst;
`else
  logic unused_drain;
  assign unused_drain = drain_req;
  assign grant        = alloc_en && !full_int && !rst;
  assign drain_done   = 1'b0;
`endif

  rob_sn_ptr #(.p_width(p_ptrwidth)) u_alloc_ptr (
    .clk (clk),
    .rst (rst),
    .inc (grant),
    .ptr (alloc_ptr)
  );

  rob_sn_ptr #(.p_width(p_ptrwidth)) u_ret_ptr (
    .clk (clk),
    .rst (rst),
    .inc (ret_ok),
    .ptr (ret_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + {{p_ptrwidth{1'b0}}, grant} - {{p_ptrwidth{1'b0}}, ret_ok};
    end
  end

  // Outputs are forced to their reset values combinationally while rst is high.
  assign alloc_cpl = grant;
  assign alloc_sn  = rst ? '0 : alloc_ptr;
  assign ret_sn    = rst ? '0 : ret_ptr;
  assign count     = rst ? '0 : count_q;
  assign full      = !rst && full_int;
  assign empty     = rst || empty_int;

endmodule
`default_nettype wire
`endif
